decodificador_hamming: RTL

Hamming(15,11) single-error-correcting decoder that sits directly downstream of the error injector and consumes its 15-bit codeword output. Two-stage pipeline: stage 1 computes and registers the syndrome, stage 2 corrects and extracts the 11 data bits. Valid/ready handshake on both sides; sustains 1 word/cycle. A saturating counter tracks corrected words for link-quality monitoring.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/decodificador_hamming_if.sv | 33 +++
 rtl/hamming_sindrome.sv | 14 +
 rtl/decodificador_hamming.sv | 98 +++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants and helpers for encoder, injector and decoder.
package hamming_pkg;

  localparam int unsigned N_COD   = 15;
  localparam int unsigned N_DADOS = 11;
  localparam int unsigned N_PAR   = 4;

  // Codeword indices of d0..d10, LSB first (parity sits at indices 0,1,3,7).
  localparam int unsigned IDX_DADOS [N_DADOS] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  // Syndrome bit k covers every index whose position (index+1) has bit k set.
  function automatic logic [N_PAR-1:0] calc_sindrome(input logic [N_COD-1:0] c);
    logic [N_PAR-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < N_COD; i++) begin
      for (int unsigned k = 0; k < N_PAR; k++) begin
        if (((i + 1) & (32'd1 << k)) != 0) begin
          s[k] = s[k] ^ c[4'(i)];
        end
      end
    end
    return s;
  endfunction

  // Gathers the 11 data bits out of a (corrected) codeword.
  function automatic logic [N_DADOS-1:0] extrai_dados(input logic [N_COD-1:0] c);
    logic [N_DADOS-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < N_DADOS; j++) begin
      d[4'(j)] = c[4'(IDX_DADOS[j])];
    end
    return d;
  endfunction

endpackage

// File: rtl/decodificador_hamming_if.sv
// Codeword-in / data-out stream bundle of the Hamming decoder.
interface decodificador_hamming_if
  import hamming_pkg::*;
#(
  parameter int unsigned CONT_W = 16
);

  logic [N_COD-1:0]   entrada;
  logic               entrada_valida;
  logic               entrada_pronta;
  logic [N_DADOS-1:0] saida;
  logic               saida_valida;
  logic               saida_pronta;
  logic               erro_corrigido;
  logic [N_PAR-1:0]   posicao_erro;
  logic [CONT_W-1:0]  contador_erros;
  logic               limpar_contador;

  // Environment side: produces codewords, consumes data.
  modport master (
    output entrada, entrada_valida, saida_pronta, limpar_contador,
    input  entrada_pronta, saida, saida_valida, erro_corrigido,
           posicao_erro, contador_erros
  );

  // Decoder side.
  modport slave (
    input  entrada, entrada_valida, saida_pronta, limpar_contador,
    output entrada_pronta, saida, saida_valida, erro_corrigido,
           posicao_erro, contador_erros
  );

endinterface

// File: rtl/hamming_sindrome.sv
// Combinational 15-bit codeword to 4-bit syndrome.
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [N_COD-1:0] codigo,
  output logic [N_PAR-1:0] sindrome
);

  // Syndrome straight from the parity-check rule.
  always_comb begin
    sindrome = calc_sindrome(codigo);
  end

endmodule

// File: rtl/decodificador_hamming.sv
// Two-stage Hamming(15,11) SEC decoder: stage 1 registers the syndrome,
// stage 2 corrects and extracts data; corrected words are counted.
module decodificador_hamming
  import hamming_pkg::*;
#(
  parameter int unsigned CONT_W = 16
)(
  input  logic clk,
  input  logic rst,
  decodificador_hamming_if.slave bus
);

  logic               s1_v;
  logic [N_COD-1:0]   s1_cod;
  logic [N_PAR-1:0]   s1_sind;
  logic [N_PAR-1:0]   sind_c;

  logic               s2_v;
  logic [N_DADOS-1:0] saida_q;
  logic               erro_q;
  logic [N_PAR-1:0]   pos_q;
  logic [CONT_W-1:0]  cont_q;

  logic               s2_livre;
  logic               s1_avanca;
  logic               aceita;
  logic [N_COD-1:0]   cod_corr;

  hamming_sindrome u_sindrome (
    .codigo   (bus.entrada),
    .sindrome (sind_c)
  );

  assign s2_livre  = !s2_v || bus.saida_pronta;
  assign s1_avanca = s1_v && s2_livre;
  assign aceita    = bus.entrada_valida && bus.entrada_pronta;

  // Stage 1 occupancy: fill on accept, empty when drained without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (aceita) begin
      s1_v <= 1'b1;
    end else if (s1_avanca) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 1 payload; contents are meaningless while s1_v is low.
  always_ff @(posedge clk) begin
    if (aceita) begin
      s1_cod  <= bus.entrada;
      s1_sind <= sind_c;
    end
  end

  // Flip the bit pointed to by a nonzero syndrome.
  always_comb begin
    cod_corr = s1_cod;
    if (s1_sind != '0) begin
      cod_corr[s1_sind - 4'd1] = ~s1_cod[s1_sind - 4'd1];
    end
  end

  // Stage 2 output register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      saida_q <= '0;
      erro_q  <= 1'b0;
      pos_q   <= '0;
    end else if (s1_avanca) begin
      s2_v    <= 1'b1;
      saida_q <= extrai_dados(cod_corr);
      erro_q  <= (s1_sind != '0);
      pos_q   <= s1_sind;
    end else if (bus.saida_pronta) begin
      s2_v    <= 1'b0;
    end
  end

  // Saturating count of delivered corrected words; clear wins.
  always_ff @(posedge clk) begin
    if (rst || bus.limpar_contador) begin
      cont_q <= '0;
    end else if (s2_v && bus.saida_pronta && erro_q && (cont_q != {CONT_W{1'b1}})) begin
      cont_q <= cont_q + CONT_W'(1);
    end
  end

  assign bus.entrada_pronta = !s1_v || s2_livre;
  assign bus.saida          = saida_q;
  assign bus.saida_valida   = s2_v;
  assign bus.erro_corrigido = erro_q;
  assign bus.posicao_erro   = pos_q;
  assign bus.contador_erros = cont_q;

endmodule
